// File: rtl/uart_rx_seq.sv
// uart_rx_seq: receive-path sequencer for bit timing, start validation and stop-bit check.
module uart_rx_seq #(
   parameter int DATA_BITS = 8,
   parameter int MIN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_bit_detected,
   input  logic        serial_in,
   input  logic [31:0] baud_div,
   input  logic        framing_err,
   output logic        shift_strobe,
   output logic        sbc_clear,
   output logic        sbc_enable,
   output logic        load_buffer,
   output logic        frame_error,
   output logic        false_start,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, START_CHK, DATA, STOP, SBC, EVAL} state_t;
   state_t state_q, state_d;
   logic [31:0] clk_cnt_q, clk_cnt_d, div_q, div_d, cnt_inc;
   logic [3:0] bit_cnt_q, bit_cnt_d, bit_inc;
   logic bit_end, half_hit;
   always_comb begin
      state_d = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      div_d = div_q;
      shift_strobe = 1'b0;
      sbc_clear = 1'b0;
      sbc_enable = 1'b0;
      load_buffer = 1'b0;
      frame_error = 1'b0;
      false_start = 1'b0;
      busy = state_q != IDLE;
      cnt_inc = clk_cnt_q + 32'd1;
      bit_inc = bit_cnt_q + 4'd1;
      bit_end = clk_cnt_q == div_q - 32'd1;
      half_hit = clk_cnt_q == (div_q >> 1) - 32'd1;
      case (state_q)
         IDLE: if (start_bit_detected) begin
            sbc_clear = 1'b1;
            state_d = START_CHK;
            clk_cnt_d = 32'd0;
            bit_cnt_d = 4'd0;
            div_d = (baud_div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : baud_div;
         end
         START_CHK: begin
            clk_cnt_d = half_hit ? 32'd0 : cnt_inc;
            false_start = half_hit & serial_in;
            if (half_hit) state_d = serial_in ? IDLE : DATA;
         end
         DATA: begin
            clk_cnt_d = bit_end ? 32'd0 : cnt_inc;
            shift_strobe = bit_end;
            if (bit_end) begin
               bit_cnt_d = bit_inc;
               if (bit_inc == 4'(DATA_BITS)) state_d = STOP;
            end
         end
         STOP: begin
            clk_cnt_d = bit_end ? 32'd0 : cnt_inc;
            shift_strobe = bit_end;
            if (bit_end) state_d = SBC;
         end
         SBC: begin
            sbc_enable = 1'b1;
            state_d = EVAL;
         end
         EVAL: begin
            load_buffer = ~framing_err;
            frame_error = framing_err;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         clk_cnt_q <= 32'd0;
         bit_cnt_q <= 4'd0;
         div_q <= 32'd0;
      end else begin
         state_q <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         div_q <= div_d;
      end
   end
endmodule
